ring_output_arbiter: RTL
========================

RING_OUTPUT_ARBITER -- requirements
Module: ring_output_arbiter

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, giving the slots per requester class.
REQ-002 SHALL have parameter TS_W, default 16, giving the timestamp width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, giving the consecutive local-starved grant cycles before a forced local grant.
REQ-004 SHALL have port clk, input, 1 bit, clock.
REQ-005 SHALL have port rst_n, input, 1 bit, reset, asynchronous, active-low.
REQ-006 SHALL have port clk_counter, input, TS_W bits, free-running cycle count used for age.
REQ-007 SHALL have port backpressure, input, 1 bit; high means the downstream router cannot accept.
REQ-008 SHALL have port ring_req, input, NUM_SLOTS bits, per-slot valid for the through-traffic (ring) buffer.
REQ-009 SHALL have port ring_ts, input, NUM_SLOTS*TS_W bits; slot i occupies bits [i*TS_W +: TS_W].
REQ-010 SHALL have port local_req, input, NUM_SLOTS bits, per-slot valid for the local injection buffer.
REQ-011 SHALL have port local_ts, input, NUM_SLOTS*TS_W bits, same packing as ring_ts.
REQ-012 SHALL have port grant_valid, output, 1 bit, registered; high when a grant is issued this cycle.
REQ-013 SHALL have port grant_local, output, 1 bit; 0 = ring slot granted, 1 = local slot granted.
REQ-014 SHALL have port grant_onehot, output, NUM_SLOTS bits, one-hot slot index of the grant; all zero when grant_valid is 0.
REQ-015 SHALL have port starve_events, output, 32 bits, count of forced local grants.

Function
REQ-016 SHALL compute slot age as (clk_counter - ts) modulo 2^TS_W, so timestamp wrap-around stays correct.
REQ-017 SHALL select within a class the valid slot of largest age; ties go to the lowest index.
REQ-018 SHALL register all grant outputs: a request visible in cycle N yields a grant in cycle N+1.
REQ-019 SHALL exclude from the cycle-N+1 computation the slot granted in cycle N, because the requester clears it on that edge and must not be granted twice.
REQ-020 SHALL issue no grant while backpressure is high: grant_valid = 0, grant_onehot = 0, and FSM state and starve counter hold.
REQ-021 SHALL use a two-state FSM with states RING_PRIO and LOCAL_FORCE.
REQ-022 SHALL, in RING_PRIO, grant the oldest ring slot if any eligible ring slot exists, else the oldest local slot, else nothing.
REQ-023 SHALL, in LOCAL_FORCE, grant the oldest eligible local slot and return to RING_PRIO after that single grant.
REQ-024 SHALL increment the starve counter in each cycle where a ring slot is granted while at least one eligible local slot exists.
REQ-025 SHALL clear the starve counter on any local grant, and also in any cycle where no eligible local slot exists.
REQ-026 SHALL move from RING_PRIO to LOCAL_FORCE when the starve counter reaches STARVE_LIMIT.
REQ-027 SHALL increment starve_events on each LOCAL_FORCE grant; the counter wraps at 2^32.
REQ-028 SHALL return to RING_PRIO without granting if in LOCAL_FORCE all local slots drop.
REQ-029 SHALL size the starve counter as $clog2(STARVE_LIMIT+1) bits, saturating at STARVE_LIMIT.

Reset
REQ-030 SHALL, on rst_n low, immediately force grant_valid = 0, grant_local = 0, grant_onehot = 0, starve_events = 0, starve counter = 0, state = RING_PRIO, and the exclusion mask = 0.
REQ-031 SHALL abandon any in-flight grant on reset mid-operation, and SHALL issue its first grant no earlier than the second rising edge after rst_n deasserts.

Structure
REQ-032 SHALL place the FSM state enum (RING_PRIO, LOCAL_FORCE) and the age-compute width constants in a shared package, ring_noc_pkg.
REQ-033 SHALL implement the per-class oldest-slot selection as one sub-module, oldest_slot_select, instantiated once for ring and once for local.
REQ-034 SHALL contain no packet-data storage; the arbiter handles indices and timestamps only.

Verification
REQ-035 Bench SHALL cover: ring_req=0101, ring_ts={slot0:10, slot2:4}, clk_counter=20 -> next cycle grant_onehot=0100, grant_local=0.
REQ-036 Bench SHALL cover: clk_counter=3, ring slot1 ts=65530 (age 9), slot3 ts=1 (age 2) -> slot1 granted.
REQ-037 Bench SHALL cover: ring_req=1111 and local_req=0001 held with no backpressure -> 8 ring grants, then grant_local=1, grant_onehot=0001, starve_events=1.
REQ-038 Bench SHALL cover: backpressure high for 5 cycles with requests pending -> grant_valid=0 throughout, starve counter unchanged, grant in the cycle after release.
REQ-039 Bench SHALL cover: slot2 granted in cycle N and ring_req[2] still high in cycle N -> slot2 not granted in cycle N+1.
REQ-040 Bench SHALL cover: rst_n low while in LOCAL_FORCE -> all outputs 0 asynchronously, state RING_PRIO after release.

Source files
------------

// File: rtl/ring_noc_pkg.sv
// Shared types and width constants for the ring output arbiter and its slot selectors.
package ring_noc_pkg;

  localparam int unsigned NUM_SLOTS_DEFAULT    = 4;
  localparam int unsigned TS_W_DEFAULT         = 16;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;
  localparam int unsigned EVENT_W              = 32;

  typedef enum logic [0:0] {
    RING_PRIO   = 1'b0,
    LOCAL_FORCE = 1'b1
  } arb_state_e;

endpackage

// File: rtl/oldest_slot_select.sv
// Picks the valid slot with the largest modular age; ties resolve to the lowest index.
module oldest_slot_select
  import ring_noc_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = NUM_SLOTS_DEFAULT,
  parameter int unsigned TS_W      = TS_W_DEFAULT
) (
  input  logic [TS_W-1:0]           clk_counter,
  input  logic [NUM_SLOTS-1:0]      req,
  input  logic [NUM_SLOTS*TS_W-1:0] ts,
  output logic                      found,
  output logic [NUM_SLOTS-1:0]      onehot
);

  logic [TS_W-1:0] age;
  logic [TS_W-1:0] best_age;

  always_comb begin
    found    = 1'b0;
    onehot   = '0;
    age      = '0;
    best_age = '0;
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      // Truncating subtraction keeps ages correct across timestamp wrap.
      age = clk_counter - ts[i*TS_W +: TS_W];
      if (req[i] && (!found || (age > best_age))) begin
        found     = 1'b1;
        best_age  = age;
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_output_arbiter.sv
// Ring-vs-local output arbiter: ring traffic has priority, with a forced local grant after
// STARVE_LIMIT consecutive ring grants that starved a waiting local slot.
module ring_output_arbiter
  import ring_noc_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = NUM_SLOTS_DEFAULT,
  parameter int unsigned TS_W         = TS_W_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [TS_W-1:0]           clk_counter,
  input  logic                      backpressure,
  input  logic [NUM_SLOTS-1:0]      ring_req,
  input  logic [NUM_SLOTS*TS_W-1:0] ring_ts,
  input  logic [NUM_SLOTS-1:0]      local_req,
  input  logic [NUM_SLOTS*TS_W-1:0] local_ts,
  output logic                      grant_valid,
  output logic                      grant_local,
  output logic [NUM_SLOTS-1:0]      grant_onehot,
  output logic [EVENT_W-1:0]        starve_events
);

  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  arb_state_e           state_q, state_d;
  logic [STARVE_W-1:0]  starve_q, starve_d;
  logic [EVENT_W-1:0]   events_q, events_d;
  logic                 gv_q, gv_d;
  logic                 gl_q, gl_d;
  logic [NUM_SLOTS-1:0] goh_q, goh_d;
  logic                 armed_q;

  logic [NUM_SLOTS-1:0] ring_mask, local_mask;
  logic [NUM_SLOTS-1:0] ring_elig, local_elig;
  logic                 ring_any, local_any;
  logic [NUM_SLOTS-1:0] ring_sel, local_sel;

  // The slot granted last cycle is being cleared by its requester on this edge.
  assign ring_mask  = (gv_q && !gl_q) ? goh_q : '0;
  assign local_mask = (gv_q && gl_q) ? goh_q : '0;
  assign ring_elig  = ring_req & ~ring_mask;
  assign local_elig = local_req & ~local_mask;

  oldest_slot_select #(
    .NUM_SLOTS(NUM_SLOTS),
    .TS_W     (TS_W)
  ) u_ring_sel (
    .clk_counter(clk_counter),
    .req        (ring_elig),
    .ts         (ring_ts),
    .found      (ring_any),
    .onehot     (ring_sel)
  );

  oldest_slot_select #(
    .NUM_SLOTS(NUM_SLOTS),
    .TS_W     (TS_W)
  ) u_local_sel (
    .clk_counter(clk_counter),
    .req        (local_elig),
    .ts         (local_ts),
    .found      (local_any),
    .onehot     (local_sel)
  );

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    events_d = events_q;
    gv_d     = 1'b0;
    gl_d     = 1'b0;
    goh_d    = '0;
    // armed_q holds off the first grant for one cycle after reset release.
    if (armed_q && !backpressure) begin
      unique case (state_q)
        RING_PRIO: begin
          if (ring_any) begin
            gv_d  = 1'b1;
            goh_d = ring_sel;
            if (local_any) begin
              starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 1'b1;
            end else begin
              starve_d = '0;
            end
          end else if (local_any) begin
            gv_d     = 1'b1;
            gl_d     = 1'b1;
            goh_d    = local_sel;
            starve_d = '0;
          end else begin
            starve_d = '0;
          end
          if (starve_d == STARVE_MAX) begin
            state_d = LOCAL_FORCE;
          end
        end
        LOCAL_FORCE: begin
          state_d  = RING_PRIO;
          starve_d = '0;
          if (local_any) begin
            gv_d     = 1'b1;
            gl_d     = 1'b1;
            goh_d    = local_sel;
            events_d = events_q + 1'b1;
          end
        end
        default: state_d = RING_PRIO;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RING_PRIO;
      starve_q <= '0;
      events_q <= '0;
      gv_q     <= 1'b0;
      gl_q     <= 1'b0;
      goh_q    <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      events_q <= events_d;
      gv_q     <= gv_d;
      gl_q     <= gl_d;
      goh_q    <= goh_d;
      armed_q  <= 1'b1;
    end
  end

  assign grant_valid   = gv_q;
  assign grant_local   = gl_q;
  assign grant_onehot  = goh_q;
  assign starve_events = events_q;

endmodule
